// File: rtl/alu_exc_pkg.sv
// alu_exc_pkg: shared cause codes, FSM states, status bit indices and ALU control codes
package alu_exc_pkg;
  localparam logic [3:0] CAUSE_NONE     = 4'd0;
  localparam logic [3:0] CAUSE_DIV0     = 4'd1;
  localparam logic [3:0] CAUSE_MULOVF   = 4'd2;
  localparam logic [3:0] CAUSE_CARRY    = 4'd3;
  localparam logic [3:0] CAUSE_MISALIGN = 4'd4;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_FLUSH} state_t;

  localparam int ST_ZERO    = 7;
  localparam int ST_MULOVF  = 6;
  localparam int ST_CARRY   = 5;
  localparam int ST_NEG     = 4;
  localparam int ST_ALIGNED = 3;
  localparam int ST_DIV0    = 2;

  localparam logic [3:0] CTL_AND = 4'd0;
  localparam logic [3:0] CTL_OR  = 4'd1;
  localparam logic [3:0] CTL_ADD = 4'd2;
  localparam logic [3:0] CTL_DIV = 4'd4;
  localparam logic [3:0] CTL_MUL = 4'd5;
  localparam logic [3:0] CTL_SUB = 4'd6;
endpackage

// File: rtl/alu_exc_detect.sv
// alu_exc_detect: masks candidate arithmetic/address traps and picks the highest-priority cause
module alu_exc_detect
  import alu_exc_pkg::*;
(
  input  logic       valid,
  input  logic       mem_op,
  input  logic [3:0] ctl,
  input  logic       div0,
  input  logic       mulovf,
  input  logic       carry,
  input  logic       aligned,
  input  logic [3:0] mask,
  output logic       trap,
  output logic [3:0] cause
);
  logic d0, mo, cy, ma;
  always_comb begin
    d0 = valid & mask[0] & (ctl == CTL_DIV) & div0;
    mo = valid & mask[1] & (ctl == CTL_MUL) & mulovf;
    cy = valid & mask[2] & ((ctl == CTL_ADD) | (ctl == CTL_SUB)) & carry & ~mem_op;
    ma = valid & mask[3] & (ctl == CTL_ADD) & mem_op & ~aligned;
    cause = d0 ? CAUSE_DIV0 : mo ? CAUSE_MULOVF : cy ? CAUSE_CARRY : ma ? CAUSE_MISALIGN : CAUSE_NONE;
    trap = d0 | mo | cy | ma;
  end
endmodule

// File: rtl/alu_exc_unit.sv
// alu_exc_unit: EX-stage trap capture, sticky flags and req/ack handshake with stall/flush.
// ALU_EXC_COUNT_EN builds the saturating trap counter; otherwise exc_count is tied to 0.
module alu_exc_unit
  import alu_exc_pkg::*;
#(
  parameter logic [3:0] MASK_RST = 4'b1111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        mem_op,
  input  logic [3:0]  alu_control,
  input  logic [31:0] alu_result,
  input  logic [7:0]  alu_status,
  input  logic [31:0] pc_in,
  input  logic        mask_we,
  input  logic [3:0]  mask_wdata,
  input  logic        clr_flags,
  input  logic        exc_ack,
  output logic        kill,
  output logic        exc_req,
  output logic [3:0]  exc_cause,
  output logic [31:0] epc,
  output logic [31:0] badval,
  output logic        stall,
  output logic        flush,
  output logic [7:0]  sticky,
  output logic [7:0]  exc_count
);
  state_t     state;
  logic [3:0] mask;
  logic       live, trap;
  logic [3:0] cause;
  assign live = valid_in & (state == S_IDLE);
  assign kill = trap;

  alu_exc_detect u_detect (
    .valid  (live),
    .mem_op (mem_op),
    .ctl    (alu_control),
    .div0   (alu_status[ST_DIV0]),
    .mulovf (alu_status[ST_MULOVF]),
    .carry  (alu_status[ST_CARRY]),
    .aligned(alu_status[ST_ALIGNED]),
    .mask   (mask),
    .trap   (trap),
    .cause  (cause)
  );

  // clear is applied before the new status bits are OR-ed in
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      exc_req   <= 1'b0;
      stall     <= 1'b0;
      flush     <= 1'b0;
      exc_cause <= CAUSE_NONE;
      epc       <= '0;
      badval    <= '0;
      sticky    <= '0;
      mask      <= MASK_RST;
    end else begin
      if (mask_we) mask <= mask_wdata;
      if (live) sticky <= (clr_flags ? 8'h00 : sticky) | (alu_status & 8'hFC);
      else if (clr_flags) sticky <= '0;
      case (state)
        S_IDLE: if (trap) begin
          state     <= S_REQ;
          exc_req   <= 1'b1;
          stall     <= 1'b1;
          exc_cause <= cause;
          epc       <= pc_in;
          badval    <= alu_result;
        end
        S_REQ: if (exc_ack) begin
          state   <= S_FLUSH;
          exc_req <= 1'b0;
          flush   <= 1'b1;
        end
        S_FLUSH: begin
          state <= S_IDLE;
          flush <= 1'b0;
          stall <= 1'b0;
        end
        default: begin
          state   <= S_IDLE;
          exc_req <= 1'b0;
          flush   <= 1'b0;
          stall   <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALU_EXC_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) exc_count <= '0;
    else if (trap && exc_count != 8'hFF) exc_count <= exc_count + 8'd1;
  end
`else
  assign exc_count = '0;
`endif
endmodule

// File: tb/tb_alu_exc_unit.sv
// tb_alu_exc_unit: vector table, directed corner sequences and random stimulus vs a reference model
module tb_alu_exc_unit;
  logic        clk = 1'b0, rst = 1'b0;
  logic        valid_in = 1'b0, mem_op = 1'b0, mask_we = 1'b0, clr_flags = 1'b0, exc_ack = 1'b0;
  logic [3:0]  alu_control = '0, mask_wdata = '0;
  logic [31:0] alu_result = '0, pc_in = '0;
  logic [7:0]  alu_status = '0;
  logic        kill, exc_req, stall, flush;
  logic [3:0]  exc_cause;
  logic [31:0] epc, badval;
  logic [7:0]  sticky, exc_count;

  int total = 0, bad = 0;

  int          m_phase = 0;
  logic [3:0]  m_mask = 4'hF, m_cause = '0;
  logic [31:0] m_epc = '0, m_badval = '0;
  logic [7:0]  m_sticky = '0;
  int          m_count = 0;

  alu_exc_unit dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .mem_op(mem_op), .alu_control(alu_control),
    .alu_result(alu_result), .alu_status(alu_status), .pc_in(pc_in), .mask_we(mask_we),
    .mask_wdata(mask_wdata), .clr_flags(clr_flags), .exc_ack(exc_ack), .kill(kill),
    .exc_req(exc_req), .exc_cause(exc_cause), .epc(epc), .badval(badval), .stall(stall),
    .flush(flush), .sticky(sticky), .exc_count(exc_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ctl;
    logic        mem;
    logic [31:0] res;
    logic [7:0]  st;
    logic [31:0] pc;
    logic [3:0]  exp_cause;
  } vec_t;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%h exp=%h at %0t", n, a, e, $time);
    end
  endtask

  function automatic logic [3:0] cause_of(input logic [3:0] c, input logic m, input logic [7:0] s, input logic [3:0] k);
    if (c == 4 && s[2] && k[0]) return 4'd1;
    if (c == 5 && s[6] && k[1]) return 4'd2;
    if ((c == 2 || c == 6) && s[5] && !m && k[2]) return 4'd3;
    if (c == 2 && m && !s[3] && k[3]) return 4'd4;
    return 4'd0;
  endfunction

  function automatic logic exp_kill();
    return valid_in && m_phase == 0 && cause_of(alu_control, mem_op, alu_status, m_mask) != 0;
  endfunction

  task automatic model_edge();
    logic [3:0] c;
    if (rst) begin
      m_phase = 0; m_mask = 4'hF; m_cause = 0; m_epc = 0; m_badval = 0; m_sticky = 0; m_count = 0;
      return;
    end
    c = (m_phase == 0 && valid_in) ? cause_of(alu_control, mem_op, alu_status, m_mask) : 4'd0;
    if (m_phase == 0 && valid_in) m_sticky = (clr_flags ? 8'h00 : m_sticky) | {alu_status[7:2], 2'b00};
    else if (clr_flags) m_sticky = 0;
    if (mask_we) m_mask = mask_wdata;
    if (m_phase == 0 && c != 0) begin
      m_phase = 1; m_cause = c; m_epc = pc_in; m_badval = alu_result;
`ifdef ALU_EXC_COUNT_EN
      if (m_count < 255) m_count++;
`endif
    end else if (m_phase == 1) begin
      if (exc_ack) m_phase = 2;
    end else if (m_phase == 2) m_phase = 0;
  endtask

  task automatic cycle();
    #2;
    chk("kill", kill, exp_kill());
    @(posedge clk);
    model_edge();
    #1;
    chk("exc_req", exc_req, m_phase == 1);
    chk("stall", stall, m_phase != 0);
    chk("flush", flush, m_phase == 2);
    chk("exc_cause", exc_cause, m_cause);
    chk("epc", epc, m_epc);
    chk("badval", badval, m_badval);
    chk("sticky", sticky, m_sticky);
    chk("exc_count", exc_count, m_count);
  endtask

  task automatic drive(input logic v, input logic [3:0] c, input logic m, input logic [31:0] r,
                       input logic [7:0] s, input logic [31:0] p);
    valid_in = v; alu_control = c; mem_op = m; alu_result = r; alu_status = s; pc_in = p;
    mask_we = 0; clr_flags = 0; exc_ack = 0; rst = 0;
  endtask

  task automatic idle_in();
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic ack_out();
    idle_in(); exc_ack = 1; cycle();
    idle_in(); cycle();
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{4'd4, 1'b0, 32'h0000_0000, 8'h84, 32'h100,  4'd1};
    vecs[1] = '{4'd2, 1'b1, 32'h0000_1002, 8'h00, 32'h104,  4'd4};
    vecs[2] = '{4'd2, 1'b1, 32'h0000_1004, 8'h08, 32'h108,  4'd0};
    vecs[3] = '{4'd5, 1'b0, 32'h8000_0000, 8'h40, 32'h10C,  4'd2};
    vecs[4] = '{4'd2, 1'b0, 32'h0000_0001, 8'h20, 32'h110,  4'd3};
    vecs[5] = '{4'd6, 1'b0, 32'hFFFF_FFFF, 8'h30, 32'h114,  4'd3};
    vecs[6] = '{4'd2, 1'b1, 32'h0000_2000, 8'h28, 32'h118,  4'd0};
    vecs[7] = '{4'd4, 1'b0, 32'h0000_0007, 8'h64, 32'h11C,  4'd1};
    vecs[8] = '{4'd0, 1'b0, 32'h0000_0000, 8'hFC, 32'h120,  4'd0};

    idle_in(); rst = 1; cycle(); cycle();
    idle_in(); cycle();
    chk("reset_req", exc_req, 0);
    chk("reset_sticky", sticky, 0);

    foreach (vecs[i]) begin
      drive(1, vecs[i].ctl, vecs[i].mem, vecs[i].res, vecs[i].st, vecs[i].pc);
      #2;
      chk("vec_kill", kill, vecs[i].exp_cause != 0);
      cycle();
      if (vecs[i].exp_cause != 0) begin
        chk("vec_cause", exc_cause, vecs[i].exp_cause);
        chk("vec_epc", epc, vecs[i].pc);
        chk("vec_badval", badval, vecs[i].res);
        chk("vec_req", exc_req, 1);
        idle_in(); exc_ack = 1; cycle();
        chk("vec_flush", flush, 1);
        idle_in(); cycle();
        chk("vec_flush_end", flush | stall, 0);
      end else begin
        chk("vec_noreq", exc_req, 0);
        idle_in(); cycle();
      end
    end

    idle_in(); clr_flags = 1; cycle();
    idle_in(); mask_we = 1; mask_wdata = 4'b1101; cycle();
    drive(1, 5, 0, 32'h55, 8'h40, 32'h200); cycle();
    chk("mask_noreq", exc_req, 0);
    chk("mask_sticky6", sticky[6], 1);
    idle_in(); mask_we = 1; mask_wdata = 4'hF; cycle();
    drive(1, 5, 0, 32'h66, 8'h40, 32'h204); cycle();
    chk("mulovf_cause", exc_cause, 2);

    for (int i = 0; i < 3; i++) begin
      drive(1, 4, 0, 32'h77, 8'h84, 32'h300 + i); cycle();
    end
    chk("stall_cause", exc_cause, 2);
    chk("stall_epc", epc, 32'h204);
    chk("stall_sticky", sticky, 8'h40);
    ack_out();

    drive(1, 4, 0, 32'h9, 8'h84, 32'h400); cycle();
    idle_in(); mask_we = 1; mask_wdata = 4'h0; cycle();
    chk("pending_kept", exc_req, 1);
    idle_in(); rst = 1; cycle();
    idle_in(); cycle();
    chk("rst_req", exc_req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_sticky", sticky, 0);
    drive(1, 4, 0, 32'h0, 8'h04, 32'h500);
    #2;
    chk("rst_mask", kill, 1);
    cycle();
    idle_in(); exc_ack = 1; cycle();
    idle_in(); rst = 1; cycle();
    chk("rst_flush", flush, 0);
    idle_in(); cycle();

    for (int i = 0; i < 600; i++) begin
      logic [3:0] ctls[7] = '{0, 1, 2, 3, 4, 5, 6};
      drive($urandom_range(0, 3) != 0, ctls[$urandom_range(0, 6)], $urandom_range(0, 1),
            $urandom, $urandom, $urandom);
      exc_ack    = $urandom_range(0, 2) == 0;
      clr_flags  = $urandom_range(0, 15) == 0;
      mask_we    = $urandom_range(0, 15) == 0;
      mask_wdata = $urandom;
      rst        = $urandom_range(0, 63) == 0;
      cycle();
    end

    idle_in(); rst = 1; cycle();
    for (int i = 0; i < 300; i++) begin
      drive(1, 4, 0, i, 8'h04, i); cycle();
      ack_out();
    end
`ifdef ALU_EXC_COUNT_EN
    chk("count_sat", exc_count, 255);
`else
    chk("count_off", exc_count, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_exc_unit.md
# alu_exc_unit

Registered exception and flag-capture stage sitting directly downstream of the ALU in the EX stage. It samples the ALU's `control`, `result_out` and `status_out` for each valid instruction and accumulates sticky condition flags. Arithmetic traps (divide-by-zero, multiply overflow, add/sub carry-out) and misaligned address calculations are raised to the control unit through a request/acknowledge handshake. While a trap is pending it stalls the pipeline and issues a one-cycle flush.

## Interface
Parameters:
- `MASK_RST`, 4'b1111: reset value of the trap-enable mask. Bit 0 = div0, 1 = mul overflow, 2 = add/sub carry, 3 = misalign.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `valid_in`  in  1  ALU outputs belong to a live instruction this cycle.
- `mem_op`  in  1  instruction is a load/store; an ALU add is its address calculation.
- `alu_control`  in  4  ALU control code of the instruction.
- `alu_result`  in  32  ALU `result_out`.
- `alu_status`  in  8  ALU `status_out`. Bit 7 zero, 6 mul overflow, 5 carry, 4 negative, 3 word-aligned, 2 div-by-zero, 1:0 unused.
- `pc_in`  in  32  PC of the instruction.
- `mask_we`  in  1  write the trap mask.
- `mask_wdata`  in  4  new mask value.
- `clr_flags`  in  1  clear the sticky flags.
- `exc_ack`  in  1  control unit has accepted the request.
- `kill`  out  1  combinational; suppresses commit of the trapping instruction.
- `exc_req`  out  1  trap pending.
- `exc_cause`  out  4  cause code.
- `epc`  out  32  PC of the trapping instruction.
- `badval`  out  32  `alu_result` of the trapping instruction.
- `stall`  out  1  hold upstream stages.
- `flush`  out  1  one-cycle pipeline flush.
- `sticky`  out  8  accumulated status bits.
- `exc_count`  out  8  saturating trap counter.

## Operation
- Trap detection is combinational, evaluated only when `valid_in`.
  - div0: `alu_control`=4 and status[2].
  - mul overflow: `alu_control`=5 and status[6].
  - carry: `alu_control` in {2,6}, status[5], and not `mem_op`.
  - misalign: `alu_control`=2, `mem_op`, and status[3]=0.
- Each candidate trap is gated by its mask bit.
- Priority: div0 > mul overflow > carry > misalign.
- Cause codes: NONE=0, DIV0=1, MULOVF=2, CARRY=3, MISALIGN=4.
- FSM states: IDLE, REQ, FLUSH.
  - IDLE: a trap with `valid_in` loads `exc_cause`, `epc` and `badval`, then goes to REQ.
  - REQ: holds until `exc_ack`, then goes to FLUSH.
  - FLUSH: one cycle, then back to IDLE.
- `kill` = `valid_in` & trap & (state==IDLE).
- Sticky flags: in IDLE with `valid_in`, `sticky` <= `sticky` | {status[7:2], 2'b00}.
  - `clr_flags` in the same cycle: `sticky` <= new bits only, so clear applies first and the new OR lands.
  - `clr_flags` alone: `sticky` <= 0.
- In REQ and FLUSH, `valid_in` is ignored entirely: no sticky update, no detection. Upstream holds because `stall` is high.
- `mask_we` takes effect on the next cycle in any state. It does not cancel a pending request.
- `exc_count` increments on each IDLE→REQ transition and saturates at 255.

## Timing
- Reset values:
  - state IDLE.
  - `exc_req`, `stall`, `flush`, `kill` = 0.
  - `exc_cause` = 0, `epc` = 0, `badval` = 0, `sticky` = 0, `exc_count` = 0.
  - mask = `MASK_RST`.
- Trap at cycle N:
  - `kill`=1 in cycle N.
  - `exc_req`=1 and `stall`=1 from N+1.
- `exc_ack` sampled at cycle M (state REQ): FLUSH at M+1 (`flush`=1, `stall`=1, `exc_req`=0), IDLE at M+2.
- Minimum trap-to-IDLE time is 3 cycles, reached when `exc_ack` arrives in the first REQ cycle.
- `exc_ack` outside REQ is ignored.
- `exc_cause`, `epc` and `badval` stay stable from REQ entry until the next trap.
- `rst` mid-REQ or mid-FLUSH returns to IDLE next cycle with all outputs at their reset values. No flush pulse is emitted.

## Configuration
- `ALU_EXC_COUNT_EN`
  - Defined: the 8-bit saturating `exc_count` register exists.
  - Undefined: `exc_count` is tied to 0 and no counter flops are built.

## Structure
- Package `alu_exc_pkg` holds:
  - cause-code constants;
  - the FSM state enum;
  - status bit index constants (ZERO=7, MULOVF=6, CARRY=5, NEG=4, ALIGNED=3, DIV0=2);
  - ALU control code constants (AND=0, OR=1, ADD=2, DIV=4, MUL=5, SUB=6).
- Sub-module `alu_exc_detect`: combinational mask gating plus priority encoder, producing the trap signal and the cause.

## Test plan
- Div0 trap: `valid_in`, control=4, status=8'h84, pc=32'h100, mask=F → `kill`=1; next cycle `exc_req`=1, cause=1, `epc`=32'h100; `exc_ack` → `flush`=1 for one cycle, then IDLE.
- Misalign: control=2, `mem_op`=1, result=32'h1002, status[3]=0 → cause=4, `badval`=32'h1002. Same op with result=32'h1004 and status[3]=1 → no trap.
- Priority and mask: control=5 with status[6]=1, mask=4'b1101 → no trap, `sticky`[6]=1. Mask=F → cause=2.
- Stall window: assert `valid_in` with trapping status during REQ → `sticky`, `exc_cause` and `exc_count` unchanged.
- Reset mid-REQ: `rst`=1 → next cycle `exc_req`=`stall`=0, `sticky`=0, mask=`MASK_RST`.
- Counter: 300 acknowledged traps with `ALU_EXC_COUNT_EN` → `exc_count`=255. Without the macro → `exc_count`=0.
